// File: rtl/seven_seg_defs.sv
// Shared constants and FSM encoding for the score display encoder.
// Digit geometry, saturation limit and double-dabble shift count.
package seven_seg_defs;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 3;
  localparam int MAX_MAG    = 999;
  localparam int SHIFT_BITS = 10;
  localparam int CNT_W      = $clog2(SHIFT_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 when the nibble is 5 or more.
// Ports: digit (BCD nibble in), adj (corrected nibble out).
module bcd_add3
  import seven_seg_defs::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adj
);

  assign adj = (digit >= BCD_W'(5)) ? digit + BCD_W'(3) : digit;

endmodule

// File: rtl/signed_score_bcd_encoder.sv
// Signed score to sign flag + 3 saturated BCD digits, one shift/clock.
// Ports: clk, rst, start/value in; ready, done, neg, ovf, hundreds/tens/ones out.
module signed_score_bcd_encoder
  import seven_seg_defs::*;
#(
  parameter int IN_W = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] value,
  output logic            ready,
  output logic            done,
  output logic            neg,
  output logic            ovf,
  output logic [3:0]      hundreds,
  output logic [3:0]      tens,
  output logic [3:0]      ones
);

  localparam int MW = (IN_W > SHIFT_BITS) ? IN_W : SHIFT_BITS;
  localparam int BW = NUM_DIGITS * BCD_W;

  state_t state;
  state_t state_n;

  logic [IN_W-1:0]       in_r;
  logic [IN_W-1:0]       mag;
  logic [MW-1:0]         mag_ext;
  logic                  sat;
  logic [SHIFT_BITS-1:0] bin;
  logic [BW-1:0]         bcd;
  logic [BW-1:0]         adj;
  logic [BW+SHIFT_BITS-1:0] sh;
  logic [CNT_W-1:0]      cnt;
  logic                  last;
  logic                  neg_r;
  logic                  ovf_r;

  // Unsigned negate: the most negative input maps to 2^(IN_W-1).
  assign mag     = in_r[IN_W-1] ? (~in_r + 1'b1) : in_r;
  assign mag_ext = MW'(mag);
  assign sat     = mag_ext > MW'(MAX_MAG);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .digit (bcd[i*BCD_W +: BCD_W]),
      .adj   (adj[i*BCD_W +: BCD_W])
    );
  end

  assign sh   = {adj, bin} << 1;
  assign last = cnt == CNT_W'(SHIFT_BITS - 1);

  assign ready = state == IDLE;
  assign done  = state == DONE;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = LOAD;
      LOAD:  state_n = SHIFT;
      SHIFT: if (last) state_n = DONE;
      DONE:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_r     <= '0;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      neg_r    <= 1'b0;
      ovf_r    <= 1'b0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) in_r <= value;
        LOAD: begin
          bin   <= sat ? SHIFT_BITS'(MAX_MAG)
                       : mag_ext[SHIFT_BITS-1:0];
          bcd   <= '0;
          neg_r <= in_r[IN_W-1];
          ovf_r <= sat;
          cnt   <= '0;
        end
        SHIFT: begin
          {bcd, bin} <= sh;
          cnt        <= cnt + 1'b1;
          // Publish straight from the final shift result.
          if (last) begin
            hundreds <= sh[SHIFT_BITS+2*BCD_W +: BCD_W];
            tens     <= sh[SHIFT_BITS+BCD_W +: BCD_W];
            ones     <= sh[SHIFT_BITS +: BCD_W];
            neg      <= neg_r;
            ovf      <= ovf_r;
          end
        end
        DONE: ;
      endcase
    end
  end

endmodule
